// File: rtl/prod_accumulator.sv
// -----------------------------------------------------------------------------
// prod_accumulator
//
// Sums a stream of unsigned 2N-bit products, such as those coming out of
// n_bit_multiplier, over a frame that ends with in_last. When the frame ends,
// the stage presents three results: the saturated sum, the saturated beat
// count, and a sticky overflow flag.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer holding valid high keeps its payload stable until that transfer.
//   in_ready depends only on the FSM state. It has no combinational path from
//   in_valid or out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   product beat valid
//   in_ready   stage can accept a beat (high only in ACCUM)
//   prod       unsigned product, 2*N bits, zero-extended into the accumulator
//   in_last    final beat of the frame, qualified by in_valid & in_ready
//   out_valid  frame result valid (registered)
//   out_ready  downstream accepts the result
//   out_sum    frame sum, saturates at all ones (ACC_W bits)
//   out_count  number of beats in the frame, saturates at all ones (CNT_W bits)
//   out_ovf    the sum saturated at some point during the frame
// -----------------------------------------------------------------------------
module prod_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 2 * N + 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Zero-fill that widens prod to ACC_W+1 bits, so the adder keeps its carry.
  localparam int PAD_W = ACC_W + 1 - 2 * N;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  // Values of the frame state once the beat on the bus is included.
  logic [ACC_W:0]   sum_wide;
  logic             sum_carry;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             ovf_upd;

  logic accept;
  logic out_fire;

  // ---------------------------------------------------------------------------
  // Update datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    sum_wide  = {1'b0, acc} + {{PAD_W{1'b0}}, prod};
    // The carry out of the ACC_W+1-bit add is exactly "sum exceeds all ones".
    sum_carry = sum_wide[ACC_W];
    acc_upd   = sum_carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    ovf_upd   = ovf | sum_carry;
    // The count sticks at its maximum instead of wrapping back to zero.
    cnt_upd   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and in_ready decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    out_fire   = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && in_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        // in_ready stays low here, even in the handshake cycle. This is what
        // guarantees at least one bubble between frames.
        out_fire = out_ready;
        if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_next;

      if (accept) begin
        acc <= acc_upd;
        cnt <= cnt_upd;
        ovf <= ovf_upd;
        if (in_last) begin
          // The result includes the closing beat itself.
          out_sum   <= acc_upd;
          out_count <= cnt_upd;
          out_ovf   <= ovf_upd;
          out_valid <= 1'b1;
        end
      end

      if (out_fire) begin
        // The frame state is cleared only once the result has been taken.
        // The outputs themselves stay frozen while HOLD waits.
        out_valid <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Sequential stage directly downstream of n_bit_multiplier.
- Consumes a stream of unsigned 2N-bit products over a valid/ready handshake and sums them over a frame terminated by in_last.
- Presents the frame sum, beat count and overflow flag on a valid/ready output.
- Typical use is dot-product / MAC datapaths built around the combinational multiplier.

Parameters:
- N, 8, multiplier operand width; input product is 2*N bits.
- ACC_W, 2*N+8, accumulator and output sum width; must be >= 2*N.
- CNT_W, 8, beat-counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  stage can accept a beat.
- prod  input  2*N  unsigned product from n_bit_multiplier.
- in_last  input  1  marks the final beat of a frame; qualified by in_valid & in_ready.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  frame sum, saturated.
- out_count  output  CNT_W  beats in frame, saturated.
- out_ovf  output  1  sum saturated during this frame.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n low at edge):
  - state=ACCUM; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Reset mid-frame discards partial sums; reset in HOLD drops the pending result.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid & in_ready.
  - Per accepted beat: next_sum = acc + zero_extend(prod), computed in ACC_W+1 bits.
  - If next_sum > 2^ACC_W-1: acc <= all ones and ovf <= 1 (sticky for the frame). Otherwise acc <= next_sum.
  - cnt <= cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - If the accepted beat has in_last=1: load out_sum, out_count and out_ovf with the updated acc, cnt and ovf values including this beat. Set out_valid <= 1 and go to HOLD.
  - Latency: result visible the cycle after the last beat is accepted.
  - in_last without in_valid is ignored.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_sum, out_count and out_ovf hold stable until the handshake.
  - On out_valid & out_ready: out_valid <= 0, acc <= 0, cnt <= 0, ovf <= 0, go to ACCUM.
  - in_ready stays 0 in the handshake cycle; the next beat is accepted no earlier than the following cycle.
  - in_valid asserted in HOLD is not consumed; upstream holds prod and in_last until accepted.
- Throughput: one beat per cycle within a frame; minimum one bubble cycle per frame.
- Outputs are registered except in_ready, which decodes state only and has no combinational path from in_valid or out_ready.
- Width rules: all arithmetic is unsigned. prod is zero-extended to ACC_W. Saturation compares using the carry out of ACC_W+1 bits.

Test Plan:
- Basic frame, N=8: beats prod=15, 100, 156 (last on 156), out_ready=1.
  -> out_valid one cycle after the third beat; out_sum=271, out_count=3, out_ovf=0. in_ready low exactly one cycle, then high.
- Single-beat frame: prod=510 with in_last=1.
  -> out_sum=510, out_count=1, out_ovf=0. Next frame starts with acc=0: beat 25 with last -> out_sum=25.
- Backpressure: complete a frame with sum 100, hold out_ready=0 for 5 cycles while in_valid=1, prod=7.
  -> out_valid and out_sum=100 stable for all 5 cycles; in_ready=0; no beat consumed. After out_ready=1 the prod=7 beat is accepted the following cycle.
- Saturation with ACC_W=17: beats 65025, 65025, 65025, 4 (last).
  -> out_sum=131071, out_ovf=1, out_count=4. The next frame (beat 9, last) gives out_sum=9, out_ovf=0.
- Count saturation with CNT_W=2: five beats of 1, last on the fifth.
  -> out_count=3, out_sum=5.
- Reset mid-operation:
  - Two beats of 50 accepted, then rst_n=0 for 1 cycle. -> All outputs 0 and in_ready=1 after reset; a beat of 3 with last gives out_sum=3, out_count=1.
  - rst_n=0 in HOLD -> out_valid=0 the next cycle.
